button_conditioner: RTL and testbench

Multi-channel successor to the two-flop button synchronizer. Each channel synchronizes a raw asynchronous button input through a parametrised flip-flop chain, debounces it with a per-channel counter, and emits a clean level plus single-cycle press/release pulses. It sits between the board pins and all control FSMs, so downstream logic never sees metastable or bouncing inputs.

---
 rtl/button_conditioner.sv | 60 ++++++
 tb/tb_button_conditioner.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// Per-channel button conditioner: synchronizer chain, debounce counter, clean level and
// single-cycle press/release pulses. The release pulse port is release_pulse because
// "release" is a reserved word.
module button_conditioner #(
  parameter int CHANNELS        = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] button,
  output logic [CHANNELS-1:0] stable,
  output logic [CHANNELS-1:0] press,
  output logic [CHANNELS-1:0] release_pulse
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    logic [CW-1:0]          count_q;
    logic                   stable_q;
    logic                   press_q;
    logic                   release_q;
    logic                   sync_out;

    assign sync_out = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
      if (rst) begin
        sync_q    <= '0;
        count_q   <= '0;
        stable_q  <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        sync_q    <= {sync_q[SYNC_STAGES-2:0], button[i]};
        press_q   <= 1'b0;
        release_q <= 1'b0;
        if (sync_out == stable_q) begin
          count_q <= '0;
        end else if (count_q == CNT_MAX) begin
          // The mismatch has persisted long enough: accept the new level.
          stable_q  <= sync_out;
          count_q   <= '0;
          press_q   <= sync_out;
          release_q <= ~sync_out;
        end else begin
          count_q <= count_q + CW'(1);
        end
      end
    end

    assign stable[i]        = stable_q;
    assign press[i]         = press_q;
    assign release_pulse[i] = release_q;
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: directed scenarios plus random button activity, all
// compared against a windowed reference model of the debounce rule.
module tb_button_conditioner;
  localparam int CH = 4;
  localparam int S  = 2;
  localparam int DC = 4;
  localparam int W  = 3 * CH;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [CH-1:0] button = '0;
  logic [CH-1:0] stable;
  logic [CH-1:0] press;
  logic [CH-1:0] release_pulse;

  int checks = 0;
  int passes = 0;

  button_conditioner #(.CHANNELS(CH), .SYNC_STAGES(S), .DEBOUNCE_CYCLES(DC)) dut (
    .clk(clk), .rst(rst), .button(button),
    .stable(stable), .press(press), .release_pulse(release_pulse)
  );

  always #5 clk = ~clk;

  // Reference model: a level is accepted when the last DC synchronized samples, all taken
  // since the previous reset or acceptance on that channel, differ from the current level.
  logic [W-1:0]  exp_q[$];
  logic [CH-1:0] hist[$];
  logic [CH-1:0] win[$];
  int            last_event[CH];
  int            edge_n = 0;
  logic [CH-1:0] m_stable  = '0;
  logic [CH-1:0] m_press   = '0;
  logic [CH-1:0] m_release = '0;

  task automatic tick();
    logic [CH-1:0] b;
    logic [CH-1:0] s;
    logic          r;
    bit            all_diff;
    b = button;
    r = rst;
    @(posedge clk);
    #1;
    edge_n++;
    m_press   = '0;
    m_release = '0;
    if (r) begin
      m_stable = '0;
      hist.delete();
      for (int k = 0; k < S; k++) hist.push_back('0);
      win.delete();
      for (int c = 0; c < CH; c++) last_event[c] = edge_n;
    end else begin
      s = hist.pop_front();
      hist.push_back(b);
      win.push_back(s);
      if (win.size() > DC) void'(win.pop_front());
      for (int c = 0; c < CH; c++) begin
        if (edge_n - last_event[c] >= DC) begin
          all_diff = 1'b1;
          foreach (win[j]) if (win[j][c] == m_stable[c]) all_diff = 1'b0;
          if (all_diff) begin
            m_stable[c]   = ~m_stable[c];
            m_press[c]    = m_stable[c];
            m_release[c]  = ~m_stable[c];
            last_event[c] = edge_n;
          end
        end
      end
    end
    exp_q.push_back({m_stable, m_press, m_release});
  endtask

  task automatic test_reset();
    logic [W-1:0] exp;
    rst    = 1'b1;
    button = '1;
    for (int k = 1; k <= 3; k++) begin
      tick();
      exp = exp_q.pop_front();
      checks++;
      if ({stable, press, release_pulse} !== exp)
        $display("FAIL reset_model k=%0d got=%h exp=%h", k, {stable, press, release_pulse}, exp);
      else passes++;
      checks++;
      if ({stable, press, release_pulse} !== '0)
        $display("FAIL reset_zero k=%0d got=%h exp=0", k, {stable, press, release_pulse});
      else passes++;
    end
  endtask

  task automatic test_clean_press();
    logic [W-1:0] exp;
    rst    = 1'b0;
    button = '0;
    for (int k = 0; k < 4; k++) begin
      tick();
      exp = exp_q.pop_front();
      checks++;
      if ({stable, press, release_pulse} !== exp)
        $display("FAIL idle_model got=%h exp=%h", {stable, press, release_pulse}, exp);
      else passes++;
    end
    button = 4'b0001;
    for (int k = 1; k <= 8; k++) begin
      tick();
      exp = exp_q.pop_front();
      checks++;
      if ({stable, press, release_pulse} !== exp)
        $display("FAIL press_model k=%0d got=%h exp=%h", k, {stable, press, release_pulse}, exp);
      else passes++;
      checks++;
      if ({stable[0], press[0]} !== {1'(k >= 6), 1'(k == 6)})
        $display("FAIL press_timing k=%0d got=%b%b exp=%b%b", k, stable[0], press[0],
                 1'(k >= 6), 1'(k == 6));
      else passes++;
      checks++;
      if (stable[3:1] !== 3'b000)
        $display("FAIL press_others k=%0d got=%b exp=000", k, stable[3:1]);
      else passes++;
    end
  endtask

  task automatic test_bounce();
    logic [W-1:0] exp;
    int presses = 0;
    for (int rep = 0; rep < 2; rep++) begin
      for (int k = 0; k < 6; k++) begin
        button[1] = (k < 3);
        tick();
        exp = exp_q.pop_front();
        checks++;
        if ({stable, press, release_pulse} !== exp)
          $display("FAIL bounce_model got=%h exp=%h", {stable, press, release_pulse}, exp);
        else passes++;
        checks++;
        if ({stable[1], press[1], release_pulse[1]} !== 3'b000)
          $display("FAIL bounce_reject rep=%0d k=%0d got=%b exp=000", rep, k,
                   {stable[1], press[1], release_pulse[1]});
        else passes++;
      end
    end
    button[1] = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      exp = exp_q.pop_front();
      checks++;
      if ({stable, press, release_pulse} !== exp)
        $display("FAIL bounce_hold_model got=%h exp=%h", {stable, press, release_pulse}, exp);
      else passes++;
      if (press[1] === 1'b1) presses++;
    end
    checks++;
    if (presses != 1 || stable[1] !== 1'b1)
      $display("FAIL bounce_single_press got presses=%0d stable=%b exp presses=1 stable=1",
               presses, stable[1]);
    else passes++;
  endtask

  task automatic test_release();
    logic [W-1:0] exp;
    button[2] = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      exp = exp_q.pop_front();
      checks++;
      if ({stable, press, release_pulse} !== exp)
        $display("FAIL release_setup_model got=%h exp=%h", {stable, press, release_pulse}, exp);
      else passes++;
    end
    button[2] = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      exp = exp_q.pop_front();
      checks++;
      if ({stable, press, release_pulse} !== exp)
        $display("FAIL release_model k=%0d got=%h exp=%h", k, {stable, press, release_pulse}, exp);
      else passes++;
      checks++;
      if ({stable[2], release_pulse[2]} !== {1'(k < 6), 1'(k == 6)})
        $display("FAIL release_timing k=%0d got=%b%b exp=%b%b", k, stable[2], release_pulse[2],
                 1'(k < 6), 1'(k == 6));
      else passes++;
    end
  endtask

  task automatic test_simultaneous();
    logic [W-1:0] exp;
    button = '0;
    for (int k = 0; k < 10; k++) begin
      tick();
      exp = exp_q.pop_front();
      checks++;
      if ({stable, press, release_pulse} !== exp)
        $display("FAIL simul_clear_model got=%h exp=%h", {stable, press, release_pulse}, exp);
      else passes++;
    end
    button = 4'b1010;
    for (int k = 1; k <= 8; k++) begin
      tick();
      exp = exp_q.pop_front();
      checks++;
      if ({stable, press, release_pulse} !== exp)
        $display("FAIL simul_model k=%0d got=%h exp=%h", k, {stable, press, release_pulse}, exp);
      else passes++;
      checks++;
      if (press !== ((k == 6) ? 4'b1010 : 4'b0000))
        $display("FAIL simul_press k=%0d got=%b exp=%b", k, press,
                 (k == 6) ? 4'b1010 : 4'b0000);
      else passes++;
      checks++;
      if ({stable[2], stable[0], release_pulse} !== 6'b0)
        $display("FAIL simul_untouched k=%0d got=%b exp=000000", k,
                 {stable[2], stable[0], release_pulse});
      else passes++;
    end
  endtask

  task automatic test_reset_mid_count();
    logic [W-1:0] exp;
    button = '0;
    for (int k = 0; k < 10; k++) begin
      tick();
      exp = exp_q.pop_front();
      checks++;
      if ({stable, press, release_pulse} !== exp)
        $display("FAIL midrst_clear_model got=%h exp=%h", {stable, press, release_pulse}, exp);
      else passes++;
    end
    button = 4'b0001;
    for (int k = -3; k <= 8; k++) begin
      rst = (k == 0);
      tick();
      exp = exp_q.pop_front();
      checks++;
      if ({stable, press, release_pulse} !== exp)
        $display("FAIL midrst_model k=%0d got=%h exp=%h", k, {stable, press, release_pulse}, exp);
      else passes++;
      checks++;
      if ({stable[0], press[0], release_pulse[0]} !== {1'(k >= 6), 1'(k == 6), 1'b0})
        $display("FAIL midrst_timing k=%0d got=%b exp=%b", k,
                 {stable[0], press[0], release_pulse[0]}, {1'(k >= 6), 1'(k == 6), 1'b0});
      else passes++;
    end
    rst = 1'b0;
  endtask

  task automatic test_random();
    logic [W-1:0]  exp;
    logic [CH-1:0] prev_pulse = '0;
    int            hold;
    for (int seg = 0; seg < 150; seg++) begin
      button = CH'($urandom);
      rst    = ($urandom_range(0, 19) == 0);
      hold   = rst ? 1 : $urandom_range(1, 7);
      for (int k = 0; k < hold; k++) begin
        tick();
        exp = exp_q.pop_front();
        checks++;
        if ({stable, press, release_pulse} !== exp)
          $display("FAIL random_model seg=%0d got=%h exp=%h", seg,
                   {stable, press, release_pulse}, exp);
        else passes++;
        checks++;
        if (((press & release_pulse) | ((press | release_pulse) & prev_pulse)) !== '0)
          $display("FAIL random_pulse_shape seg=%0d got press=%b release=%b prev=%b exp no overlap",
                   seg, press, release_pulse, prev_pulse);
        else passes++;
        prev_pulse = press | release_pulse;
        rst = 1'b0;
      end
    end
  endtask

  initial begin
    for (int k = 0; k < S; k++) hist.push_back('0);
    for (int c = 0; c < CH; c++) last_event[c] = 0;
    test_reset();
    test_clean_press();
    test_bounce();
    test_release();
    test_simultaneous();
    test_reset_mid_count();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
